ldpc_3gpp_dec_obuffer_nd: RTL

//  N-bank (2**pBNUM_W) output ping-pong buffer for the LDPC 3GPP decoder, with a per-bank tag and built-in bank control.

---
 rtl/ldpc_3gpp_dec_obuffer_pkg.sv | 30 +++
 rtl/codec_mem_block.sv | 44 ++++
 rtl/ldpc_3gpp_dec_obuffer_bctrl.sv | 66 ++++++
 rtl/ldpc_3gpp_dec_obuffer_nd.sv | 106 ++++++++++
 4 files changed

// File: rtl/ldpc_3gpp_dec_obuffer_pkg.sv
// rtl/ldpc_3gpp_dec_obuffer_pkg.sv - shared types, read latency and flag decode for the N-bank output buffer
package ldpc_3gpp_dec_obuffer_pkg;

   // ram read latency seen at the buffer ports (registered read plus one pipe stage)
   localparam int cRAM_READ_LAT = 2;

   // default bank geometry; instances with another pBNUM_W size their own vectors
   localparam int cBNUM_W_DEF = 2;

   typedef logic [cBNUM_W_DEF-1:0] bank_idx_t;
   typedef logic [cBNUM_W_DEF:0]   bank_cnt_t;

   typedef struct packed {
      logic empty;
      logic emptya;
      logic full;
      logic fulla;
   } flags_t;

   // status flags for a given number of committed banks
   function automatic flags_t decode_flags(input int unsigned cnt, input int unsigned nbank);
      flags_t f;
      f.empty  = (cnt == 0);
      f.emptya = (cnt <= 1);
      f.full   = (cnt == nbank);
      f.fulla  = ((cnt + 1) >= nbank);
      return f;
   endfunction

endpackage

// File: rtl/codec_mem_block.sv
// rtl/codec_mem_block.sv - simple dual-port ram with registered read and optional output pipe
module codec_mem_block #(
   parameter int pADDR_W = 8,
   parameter int pDAT_W  = 8,
   parameter int pPIPE   = 1
) (
   input  logic               iclk,
   input  logic               iclkena,
   input  logic               iwrite,
   input  logic [pADDR_W-1:0] iwaddr,
   input  logic [pDAT_W-1:0]  iwdat,
   input  logic [pADDR_W-1:0] iraddr,
   output logic [pDAT_W-1:0]  ordat
);

   logic [pDAT_W-1:0] mem [2**pADDR_W];
   logic [pDAT_W-1:0] rdat;

   // write port and first read register; read of a location being written returns old data
   always_ff @(posedge iclk) begin
      if (iclkena) begin
         if (iwrite) begin
            mem[iwaddr] <= iwdat;
         end
         rdat <= mem[iraddr];
      end
   end

   generate
      if (pPIPE != 0) begin : g_pipe
         logic [pDAT_W-1:0] rdat_q;
         // extra output register for timing
         always_ff @(posedge iclk) begin
            if (iclkena) begin
               rdat_q <= rdat;
            end
         end
         assign ordat = rdat_q;
      end else begin : g_nopipe
         assign ordat = rdat;
      end
   endgenerate

endmodule

// File: rtl/ldpc_3gpp_dec_obuffer_bctrl.sv
// rtl/ldpc_3gpp_dec_obuffer_bctrl.sv - bank pointers, committed count, status flags and sticky overflow
module ldpc_3gpp_dec_obuffer_bctrl
   import ldpc_3gpp_dec_obuffer_pkg::*;
#(
   parameter int pBNUM_W = 2
) (
   input  logic               iclk,
   input  logic               ireset,
   input  logic               iclkena,
   input  logic               iwfull,
   input  logic               irempty,
   output logic [pBNUM_W-1:0] owptr,
   output logic [pBNUM_W-1:0] orptr,
   output logic               owr_ok,
   output logic               oempty,
   output logic               oemptya,
   output logic               ofull,
   output logic               ofulla,
   output logic               oovf
);

   localparam int unsigned NBANK = 2**pBNUM_W;

   logic [pBNUM_W:0] cnt;
   logic [pBNUM_W:0] cnt_nxt;
   logic             rd_ok;
   logic             wr_ok;
   flags_t           fl_nxt;

   // a release frees a bank in the same cycle, so a commit while full is legal alongside it
   assign rd_ok   = irempty & ~oempty;
   assign wr_ok   = iwfull & (~ofull | rd_ok);
   assign owr_ok  = wr_ok;
   assign cnt_nxt = cnt + (pBNUM_W+1)'(wr_ok) - (pBNUM_W+1)'(rd_ok);
   assign fl_nxt  = decode_flags(32'(cnt_nxt), NBANK);

   // pointers wrap naturally since the bank count is a power of two; flags track next count
   always_ff @(posedge iclk) begin
      if (ireset) begin
         owptr   <= '0;
         orptr   <= '0;
         cnt     <= '0;
         oempty  <= 1'b1;
         oemptya <= 1'b1;
         ofull   <= 1'b0;
         ofulla  <= 1'b0;
         oovf    <= 1'b0;
      end else if (iclkena) begin
         if (wr_ok) begin
            owptr <= owptr + pBNUM_W'(1);
         end
         if (rd_ok) begin
            orptr <= orptr + pBNUM_W'(1);
         end
         cnt     <= cnt_nxt;
         oempty  <= fl_nxt.empty;
         oemptya <= fl_nxt.emptya;
         ofull   <= fl_nxt.full;
         ofulla  <= fl_nxt.fulla;
         if ((iwfull & ~wr_ok) | (irempty & ~rd_ok)) begin
            oovf <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ldpc_3gpp_dec_obuffer_nd.sv
// rtl/ldpc_3gpp_dec_obuffer_nd.sv - N-bank output buffer with per-bank tag; LDPC_3GPP_DEC_OBUFFER_RDLEN_EN adds per-bank length
module ldpc_3gpp_dec_obuffer_nd
   import ldpc_3gpp_dec_obuffer_pkg::*;
#(
   parameter int pADDR_W  = 8,
   parameter int pDAT_W   = 8,
   parameter int pDAT_NUM = 8,
   parameter int pTAG_W   = 4,
   parameter int pBNUM_W  = 2
) (
   input  logic               iclk,
   input  logic               ireset,
   input  logic               iclkena,
   input  logic               iwrite,
   input  logic               iwfull,
   input  logic [pADDR_W-1:0] iwaddr,
   input  logic [pDAT_W-1:0]  iwdat [pDAT_NUM],
   input  logic [pTAG_W-1:0]  iwtag,
   input  logic               irempty,
   input  logic [pADDR_W-1:0] iraddr,
   output logic [pDAT_W-1:0]  ordat [pDAT_NUM],
   output logic [pTAG_W-1:0]  ortag,
   output logic [pADDR_W-1:0] ordlen,
   output logic               oempty,
   output logic               oemptya,
   output logic               ofull,
   output logic               ofulla,
   output logic               oovf
);

   localparam int NBANK = 2**pBNUM_W;

   logic [pBNUM_W-1:0] wptr;
   logic [pBNUM_W-1:0] rptr;
   logic               wr_ok;
   logic [pTAG_W-1:0]  tram [NBANK];

   ldpc_3gpp_dec_obuffer_bctrl #(
      .pBNUM_W (pBNUM_W)
   ) u_bctrl (
      .iclk    (iclk),
      .ireset  (ireset),
      .iclkena (iclkena),
      .iwfull  (iwfull),
      .irempty (irempty),
      .owptr   (wptr),
      .orptr   (rptr),
      .owr_ok  (wr_ok),
      .oempty  (oempty),
      .oemptya (oemptya),
      .ofull   (ofull),
      .ofulla  (ofulla),
      .oovf    (oovf)
   );

   // one ram per lane, bank index in the address msbs
   genvar gl;
   generate
      for (gl = 0; gl < pDAT_NUM; gl++) begin : g_lane
         codec_mem_block #(
            .pADDR_W (pADDR_W + pBNUM_W),
            .pDAT_W  (pDAT_W),
            .pPIPE   (1)
         ) u_mem (
            .iclk    (iclk),
            .iclkena (iclkena),
            .iwrite  (iwrite),
            .iwaddr  ({wptr, iwaddr}),
            .iwdat   (iwdat[gl]),
            .iraddr  ({rptr, iraddr}),
            .ordat   (ordat[gl])
         );
      end
   endgenerate

   // tag is captured only when the commit is accepted
   always_ff @(posedge iclk) begin
      if (iclkena && wr_ok) begin
         tram[wptr] <= iwtag;
      end
   end

   assign ortag = tram[rptr];

`ifdef LDPC_3GPP_DEC_OBUFFER_RDLEN_EN
   logic [pADDR_W-1:0] lram [NBANK];
   logic [pADDR_W-1:0] last_waddr;

   // remember last write address; a write in the commit cycle counts as the last one
   always_ff @(posedge iclk) begin
      if (iclkena) begin
         if (iwrite) begin
            last_waddr <= iwaddr;
         end
         if (wr_ok) begin
            lram[wptr] <= iwrite ? iwaddr : last_waddr;
         end
      end
   end

   assign ordlen = lram[rptr];
`else
   assign ordlen = '0;
`endif

endmodule
